// File: rtl/alb_op_sequencer.sv
// Command sequencer for the ALB datapath: registers one operation, holds it on the
// datapath for a settle window, then captures result/flags. Optional carry chaining: ALB_CHAIN_EN.
module alb_op_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    input  logic                  cmd_chain,
    output logic [1:0]            alu_sel,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic                  alu_ci,
    input  logic [DATA_WIDTH-1:0] alu_f,
    input  logic                  alu_co,
    input  logic                  alu_vo,
    input  logic                  alu_no,
    input  logic                  alu_zo,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [3:0]            res_flags,
    output logic                  busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Out-of-range settle windows fall back to a single cycle.
    localparam int EXEC_EFF = (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) ? 1 : EXEC_CYCLES;
    localparam logic [3:0] CNT_LOAD = 4'(EXEC_EFF - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       cmd_fire;
    logic       carry_in;

`ifdef ALB_CHAIN_EN
    // The carry seen by a chained command is the C flag currently held in res_flags,
    // which in DONE is the result being consumed this cycle.
    assign carry_in = cmd_chain & res_flags[3];
`else
    logic unused_chain;
    assign unused_chain = cmd_chain;
    assign carry_in     = 1'b0;
`endif

    assign cmd_ready = (state == IDLE) || ((state == DONE) && res_ready);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            alu_sel   <= 2'b00;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ci    <= 1'b0;
            res_data  <= '0;
            res_flags <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) state <= EXEC;
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        res_data  <= alu_f;
                        res_flags <= {alu_co, alu_vo, alu_no, alu_zo};
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (res_ready) state <= cmd_fire ? EXEC : IDLE;
                end
                default: state <= IDLE;
            endcase
            // Datapath inputs change only on an accepted command, never in IDLE.
            if (cmd_fire) begin
                alu_sel <= cmd_op;
                alu_a   <= cmd_a;
                alu_b   <= cmd_b;
                alu_ci  <= carry_in;
                cnt     <= CNT_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_alb_op_sequencer.sv
// Directed scoreboard bench for alb_op_sequencer: four instances (settle 1, 3, 4 and
// out-of-range 0) each wired to a behavioural ALB datapath model.
module tb_alb_op_sequencer;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] f;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cv[4], cr[4], cch[4], rv[4], rr[4], bsy[4], aci[4];
    logic       aco[4], avo[4], ano[4], azo[4];
    logic [1:0] cop[4], asel[4];
    logic [7:0] ca[4], cb[4], aa[4], ab[4], af[4], rd[4];
    logic [3:0] rf[4];

    exp_t sb[$];
    logic last_c = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // {C,V,N,Z,F} for one datapath evaluation.
    function automatic logic [11:0] alb_model(logic [1:0] s, logic [7:0] a, logic [7:0] b, logic ci);
        logic [8:0] sum;
        logic [7:0] f;
        logic c, v;
        if (s[0]) begin
            sum = {1'b0, a} + {1'b0, b} + {8'b0, ci};
            f = sum[7:0];
            c = sum[8];
            v = (a[7] == b[7]) && (f[7] != a[7]);
        end else begin
            f = s[1] ? (a | b) : (a & b);
            c = 1'b0;
            v = 1'b0;
        end
        return {c, v, f[7], f == 8'h00, f};
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        alb_op_sequencer #(
            .DATA_WIDTH (8),
            .EXEC_CYCLES((g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 0)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .cmd_valid(cv[g]), .cmd_ready(cr[g]), .cmd_op(cop[g]),
            .cmd_a(ca[g]), .cmd_b(cb[g]), .cmd_chain(cch[g]),
            .alu_sel(asel[g]), .alu_a(aa[g]), .alu_b(ab[g]), .alu_ci(aci[g]),
            .alu_f(af[g]), .alu_co(aco[g]), .alu_vo(avo[g]), .alu_no(ano[g]), .alu_zo(azo[g]),
            .res_valid(rv[g]), .res_ready(rr[g]), .res_data(rd[g]), .res_flags(rf[g]),
            .busy(bsy[g])
        );
        assign {aco[g], avo[g], ano[g], azo[g], af[g]} = alb_model(asel[g], aa[g], ab[g], aci[g]);
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cmd(int i, logic [1:0] op, logic [7:0] a, logic [7:0] b, logic chain);
        cv[i] = 1'b1; cop[i] = op; ca[i] = a; cb[i] = b; cch[i] = chain;
    endtask

    // Expected result of the command currently on the cmd port, using the spec carry rule.
    task automatic push_exp(int i);
        logic ci;
        logic [11:0] m;
`ifdef ALB_CHAIN_EN
        ci = cch[i] & last_c;
`else
        ci = 1'b0;
`endif
        m = alb_model(cop[i], ca[i], cb[i], ci);
        sb.push_back('{d: m[7:0], f: m[11:8]});
        last_c = m[11];
    endtask

    // Call at a negedge with the command driven; returns at the negedge after acceptance.
    task automatic accept(int i, string tag);
        bit ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (cr[i]) begin
                push_exp(i);
                @(posedge clk);
                @(negedge clk);
                cv[i] = 1'b0;
                ok = 1;
            end else begin
                @(negedge clk);
            end
        end
        chk({tag, "_accept_timeout"}, 32'(ok), 1);
    endtask

    task automatic wait_result(int i, output int cyc);
        cyc = -1;
        for (int k = 1; k <= 40 && cyc < 0; k++) begin
            @(negedge clk);
            if (rv[i]) cyc = k;
        end
        chk("result_timeout", 32'(cyc > 0), 1);
    endtask

    // Compare the presented result against the scoreboard head (at a negedge, res_valid high).
    task automatic check_result(int i, string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_data"}, 32'(rd[i]), 32'(e.d));
            chk({tag, "_flags"}, 32'(rf[i]), 32'(e.f));
        end
    endtask

    task automatic take_result(int i, string tag);
        check_result(i, tag);
        rr[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rr[i] = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [7:0] held_d;
        logic [3:0] held_f;
        for (int i = 0; i < 4; i++) begin
            cv[i] = 0; cch[i] = 0; rr[i] = 0; cop[i] = 0; ca[i] = 0; cb[i] = 0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(cr[0]), 1);
        chk("rst_res_valid", 32'(rv[0]), 0);
        chk("rst_busy", 32'(bsy[0]), 0);
        chk("rst_res_data", 32'(rd[0]), 0);
        chk("rst_res_flags", 32'(rf[0]), 0);
        chk("rst_alu_bus", 32'({asel[0], aa[0], ab[0], aci[0]}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-EXEC on the 4-cycle instance
        drive_cmd(2, 2'b01, 8'h55, 8'h22, 1'b0);
        accept(2, "rstx");
        chk("rstx_busy", 32'(bsy[2]), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstx_async_busy", 32'(bsy[2]), 0);
        chk("rstx_async_alu_a", 32'(aa[2]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        last_c = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rstx_no_result", 32'(rv[2]), 0);
        end
        chk("rstx_res_data", 32'(rd[2]), 0);
        chk("rstx_res_flags", 32'(rf[2]), 0);
        chk("rstx_cmd_ready", 32'(cr[2]), 1);

        // EXEC_CYCLES=1: 0x7F+0x01 overflow
        drive_cmd(0, 2'b01, 8'h7F, 8'h01, 1'b0);
        accept(0, "add");
        wait_result(0, cyc);
        chk("add_latency", 32'(cyc), 1);
        chk("add_data_const", 32'(rd[0]), 32'h80);
        chk("add_flags_const", 32'(rf[0]), 32'b0110);
        take_result(0, "add");

        drive_cmd(0, 2'b00, 8'hF0, 8'h0F, 1'b0);
        accept(0, "and");
        wait_result(0, cyc);
        chk("and_data_const", 32'(rd[0]), 32'h00);
        chk("and_flags_const", 32'(rf[0]), 32'b0001);
        take_result(0, "and");
        chk("idle_hold_alu", 32'({asel[0], aa[0], ab[0]}), 32'({2'b00, 8'hF0, 8'h0F}));
        chk("idle_cmd_ready", 32'(cr[0]), 1);

        drive_cmd(0, 2'b10, 8'hF0, 8'h0F, 1'b0);
        accept(0, "or");
        wait_result(0, cyc);
        chk("or_data_const", 32'(rd[0]), 32'hFF);
        chk("or_flags_const", 32'(rf[0]), 32'b0010);
        take_result(0, "or");

        // Chained pair, second command accepted with the result handshake
        drive_cmd(0, 2'b01, 8'hFF, 8'h01, 1'b0);
        accept(0, "ch1");
        wait_result(0, cyc);
        chk("ch1_flags_const", 32'(rf[0]), 32'b1001);
        drive_cmd(0, 2'b01, 8'h00, 8'h00, 1'b1);
        rr[0] = 1'b1;
        #1;
        chk("ch_cmd_ready_done", 32'(cr[0]), 1);
        check_result(0, "ch1");
        push_exp(0);
        @(posedge clk);
        @(negedge clk);
        rr[0] = 1'b0; cv[0] = 1'b0;
        chk("ch_busy_direct", 32'(bsy[0]), 1);
        chk("ch_res_valid_low", 32'(rv[0]), 0);
`ifdef ALB_CHAIN_EN
        chk("ch_alu_ci", 32'(aci[0]), 1);
`else
        chk("ch_alu_ci", 32'(aci[0]), 0);
`endif
        wait_result(0, cyc);
`ifdef ALB_CHAIN_EN
        chk("ch2_data_const", 32'(rd[0]), 32'h01);
`else
        chk("ch2_data_const", 32'(rd[0]), 32'h00);
`endif
        take_result(0, "ch2");

        // Backpressure on the 3-cycle instance
        drive_cmd(1, 2'b01, 8'h12, 8'h34, 1'b0);
        accept(1, "bp");
        chk("bp_exec_cmd_ready", 32'(cr[1]), 0);
        wait_result(1, cyc);
        chk("bp_latency", 32'(cyc), 3);
        held_d = rd[1];
        held_f = rf[1];
        drive_cmd(1, 2'b10, 8'hA0, 8'h05, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_cmd_ready_low", 32'(cr[1]), 0);
            chk("bp_valid_held", 32'(rv[1]), 1);
            chk("bp_data_stable", 32'(rd[1]), 32'(held_d));
            chk("bp_flags_stable", 32'(rf[1]), 32'(held_f));
        end
        rr[1] = 1'b1;
        #1;
        chk("bp_cmd_ready_rise", 32'(cr[1]), 1);
        check_result(1, "bp1");
        push_exp(1);
        @(posedge clk);
        @(negedge clk);
        rr[1] = 1'b0; cv[1] = 1'b0;
        chk("bp_new_accepted", 32'(aa[1]), 32'hA0);
        chk("bp_busy", 32'(bsy[1]), 1);
        wait_result(1, cyc);
        chk("bp2_latency", 32'(cyc), 3);
        take_result(1, "bp2");

        // Out-of-range EXEC_CYCLES=0 behaves as 1
        drive_cmd(3, 2'b00, 8'h3C, 8'h0F, 1'b0);
        accept(3, "clamp");
        wait_result(3, cyc);
        chk("clamp_latency", 32'(cyc), 1);
        take_result(3, "clamp");
        chk("sb_drained", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alb_op_sequencer.md
# alb_op_sequencer

Command-level controller for the ALB datapath (result-select mux plus its three function units). It accepts one operation at a time over a valid/ready handshake and registers the operands. It then drives the datapath select, operand and carry-in lines for a programmable settle window. It captures the result word and C/V/N/Z flags into output registers and presents them on a valid/ready result port. The block sits between the instruction/test front end and the combinational ALB core, which has no storage of its own.

## Interface
- DATA_WIDTH, 8: width of operands and result.
- EXEC_CYCLES, 1: datapath settle cycles per operation; legal range 1..15.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted on a cycle where cmd_valid && cmd_ready.
- cmd_op  in  2  datapath select: 00, 10, or x1 (arithmetic group, flags C/V live).
- cmd_a, cmd_b  in  DATA_WIDTH  operands.
- cmd_chain  in  1  use the stored carry flag as carry-in.
- alu_sel  out  2  to datapath select.
- alu_a, alu_b  out  DATA_WIDTH  registered operands to the datapath.
- alu_ci  out  1  carry-in to the datapath.
- alu_f  in  DATA_WIDTH  datapath result.
- alu_co, alu_vo, alu_no, alu_zo  in  1  datapath flags.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed on a cycle where res_valid && res_ready.
- res_data  out  DATA_WIDTH  captured result.
- res_flags  out  4  captured flags {C,V,N,Z}.
- busy  out  1  high in EXEC or DONE.

## Operation
- States:
  - IDLE: cmd_ready=1.
  - EXEC: an operation is driving the datapath.
  - DONE: res_valid=1.
- IDLE -> EXEC on a command handshake.
  - Register cmd_op, cmd_a, cmd_b and the carry-in into op/operand registers.
  - Carry-in = cmd_chain ? stored C flag : 0.
  - Load the settle counter with EXEC_CYCLES-1.
- EXEC:
  - alu_sel, alu_a, alu_b and alu_ci come from the registers.
  - Counter decrements each cycle.
  - On the cycle the counter is 0, capture alu_f into res_data and {alu_co,alu_vo,alu_no,alu_zo} into res_flags, then go to DONE.
- DONE:
  - res_valid=1; res_data and res_flags are held stable until the result handshake.
  - cmd_ready = res_ready, so a new command is accepted in the same cycle the result is consumed.
- DONE exits:
  - Result handshake without a command handshake -> IDLE.
  - Result handshake with a command handshake -> EXEC directly; the new operands and carry are registered.
- Stored C flag = res_flags[3] of the most recently captured result.
  - A chained command accepted in DONE uses the flag being consumed in that cycle.
- In IDLE, alu_sel, alu_a, alu_b and alu_ci keep their last registered values. There are no spurious changes to the datapath inputs.
- Out-of-range EXEC_CYCLES is clamped to 1.
- Operand, result and flag widths are exactly DATA_WIDTH or 1 bit; the block performs no arithmetic except the counter.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - state=IDLE, counter=0.
  - cmd_ready=1, res_valid=0, busy=0.
  - res_data=0, res_flags=0, alu_sel=00, alu_a=0, alu_b=0, alu_ci=0.
- Latency: command handshake at edge N gives res_valid=1 after edge N+EXEC_CYCLES.
- Throughput: one operation per EXEC_CYCLES+1 cycles when res_ready is held at 1.
- cmd_ready is combinational from state and res_ready; res_valid and busy are registered state decodes.
- A command offered in EXEC is not accepted (cmd_ready=0).
- res_ready low in DONE: DONE holds indefinitely and the outputs are frozen.
- Reset asserted in EXEC or DONE: the operation is discarded and all outputs return to their reset values immediately. No result is delivered after release.

## Configuration
- ALB_CHAIN_EN:
  - Defined: cmd_chain is honoured as described, and the C flag is retained across operations.
  - Undefined: cmd_chain is ignored and alu_ci is always 0. The stored-carry logic is not built; res_flags is still captured normally.

## Test plan
The bench datapath model is: f_x1 = a+b+ci with co/vo, f_00 = a&b, f_10 = a|b, and C=V=0 for non-x1 selects. All scenarios use DATA_WIDTH=8.

- Reset mid-EXEC (EXEC_CYCLES=4, rst_n pulsed low during cycle 2) -> res_valid stays 0; res_data=0x00, res_flags=0000, cmd_ready=1 after release.
- op=01, a=0x7F, b=0x01, chain=0, EXEC_CYCLES=1, res_ready=1 -> res_valid one cycle after accept; res_data=0x80, flags C=0 V=1 N=1 Z=0.
- op=00, a=0xF0, b=0x0F -> res_data=0x00, flags 0001; op=10 same operands -> 0xFF, flags 0010.
- Chained pair with ALB_CHAIN_EN defined:
  - op=01 a=0xFF b=0x01 -> 0x00, C=1, Z=1.
  - Next command op=01 chain=1 a=0x00 b=0x00, accepted in the same cycle as the result handshake -> alu_ci=1, res_data=0x01.
  - Same sequence without the macro -> second result 0x00.
- Backpressure with EXEC_CYCLES=3, res_ready=0 for 5 cycles after res_valid:
  - res_data and res_flags stay stable; cmd_ready=0 throughout.
  - cmd_valid held high is accepted only in the cycle res_ready rises.
